// File: rtl/id_decode_stage_pkg.sv
// -----------------------------------------------------------------------------
// id_decode_stage_pkg
// Shared MIPS decode definitions: opcode/funct constants, the 4-bit ALU
// op_type codes consumed by the EX stage, the control-flag bundle, and a
// helper that maps R-type funct codes to ALU ops. Single source for the
// decode stage and the ALU.
// Ports: none (package).
// -----------------------------------------------------------------------------
package id_decode_stage_pkg;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_J     = 6'h02;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;

  // R-type funct codes (instr[5:0])
  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  // ALU op_type codes; ALU_NONE marks bubbles and illegal instructions
  typedef enum logic [3:0] {
    ALU_NONE = 4'd0,
    ALU_ADD  = 4'd1,
    ALU_SUB  = 4'd2,
    ALU_AND  = 4'd3,
    ALU_OR   = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_LW   = 4'd6,
    ALU_SW   = 4'd7,
    ALU_BEQ  = 4'd8,
    ALU_J    = 4'd9
  } alu_op_e;

  // Control flags carried alongside op_type into the ID/EX register
  typedef struct packed {
    logic use_imm;
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic branch;
    logic jump;
    logic illegal;
  } ctrl_t;

  // Map an R-type funct field to its ALU op; unknown functs give ALU_NONE
  function automatic alu_op_e rtype_op(input logic [5:0] funct);
    alu_op_e op;
    case (funct)
      FUNCT_ADD: op = ALU_ADD;
      FUNCT_SUB: op = ALU_SUB;
      FUNCT_AND: op = ALU_AND;
      FUNCT_OR:  op = ALU_OR;
      FUNCT_SLT: op = ALU_SLT;
      default:   op = ALU_NONE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/id_decode_stage_comb.sv
// -----------------------------------------------------------------------------
// id_decode_stage_comb
// Purely combinational instruction decoder: splits a MIPS instruction into
// ALU op_type, register indices, sign-extended immediate, jump target and
// control flags, and reports which source registers the instruction reads
// (used by the load-use hazard check).
// Ports:
//   instr    in   DATA_W   instruction word
//   op_type  out  4        ALU op code (0 = none/illegal)
//   rs/rt    out  RADDR_W  source register indices
//   dest     out  RADDR_W  write-back index (rd for R-type, rt for lw, else 0)
//   imm      out  DATA_W   sign-extended instr[15:0]
//   jtarget  out  26       instr[25:0]
//   ctrl     out  ctrl_t   control flags
//   reads_rs out  1        instruction consumes R[rs]
//   reads_rt out  1        instruction consumes R[rt]
// -----------------------------------------------------------------------------
module id_decode_stage_comb
  import id_decode_stage_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5
) (
  input  logic [DATA_W-1:0]  instr,
  output logic [3:0]         op_type,
  output logic [RADDR_W-1:0] rs,
  output logic [RADDR_W-1:0] rt,
  output logic [RADDR_W-1:0] dest,
  output logic [DATA_W-1:0]  imm,
  output logic [25:0]        jtarget,
  output ctrl_t              ctrl,
  output logic               reads_rs,
  output logic               reads_rt
);

  logic [5:0]         opcode_s;
  logic [5:0]         funct_s;
  logic [RADDR_W-1:0] rd_s;
  alu_op_e            op_s;
  alu_op_e            rop_s;
  ctrl_t              ctrl_s;
  logic [RADDR_W-1:0] dest_s;
  logic               reads_rs_s;
  logic               reads_rt_s;

  assign opcode_s = instr[31:26];
  assign funct_s  = instr[5:0];
  assign rs       = instr[21 +: RADDR_W];
  assign rt       = instr[16 +: RADDR_W];
  assign rd_s     = instr[11 +: RADDR_W];
  assign imm      = {{(DATA_W-16){instr[15]}}, instr[15:0]};
  assign jtarget  = instr[25:0];
  assign rop_s    = rtype_op(funct_s);

  // Opcode/funct decode into op, flags, destination and register-read usage
  always_comb begin
    op_s       = ALU_NONE;
    ctrl_s     = '0;
    dest_s     = '0;
    reads_rs_s = 1'b0;
    reads_rt_s = 1'b0;
    case (opcode_s)
      OPC_RTYPE: begin
        op_s = rop_s;
        if (rop_s != ALU_NONE) begin
          ctrl_s.reg_write = 1'b1;
          dest_s           = rd_s;
          reads_rs_s       = 1'b1;
          reads_rt_s       = 1'b1;
        end else begin
          ctrl_s.illegal = 1'b1;
        end
      end
      OPC_LW: begin
        op_s             = ALU_LW;
        ctrl_s.use_imm   = 1'b1;
        ctrl_s.mem_read  = 1'b1;
        ctrl_s.reg_write = 1'b1;
        dest_s           = rt;
        reads_rs_s       = 1'b1;
      end
      OPC_SW: begin
        op_s             = ALU_SW;
        ctrl_s.use_imm   = 1'b1;
        ctrl_s.mem_write = 1'b1;
        reads_rs_s       = 1'b1;
        reads_rt_s       = 1'b1;
      end
      OPC_BEQ: begin
        op_s          = ALU_BEQ;
        ctrl_s.branch = 1'b1;
        reads_rs_s    = 1'b1;
        reads_rt_s    = 1'b1;
      end
      OPC_J: begin
        op_s        = ALU_J;
        ctrl_s.jump = 1'b1;
      end
      default: begin
        ctrl_s.illegal = 1'b1;
      end
    endcase
    // Writes to $0 are architecturally discarded, so never request them
    ctrl_s.reg_write = ctrl_s.reg_write & (dest_s != '0);
  end

  assign op_type  = op_s;
  assign ctrl     = ctrl_s;
  assign dest     = dest_s;
  assign reads_rs = reads_rs_s;
  assign reads_rt = reads_rt_s;

endmodule

// File: rtl/id_decode_stage.sv
// -----------------------------------------------------------------------------
// id_decode_stage
// MIPS pipeline decode stage: decodes the fetched instruction, detects the
// load-use hazard against the instruction held in ID/EX, and registers the
// decoded fields into the ID/EX register with a valid/ready handshake,
// downstream back-pressure, flush and a single-cycle load-use bubble.
// Optional build macro: ID_PERF_CNT_EN adds saturating bubble/illegal counters.
// Ports:
//   clk, rst        in   clock (rising edge), async active-high reset
//   if_valid        in   fetched instruction valid
//   if_instr        in   fetched instruction
//   id_ready        out  stage accepts if_instr this cycle (combinational)
//   flush           in   squash incoming/held instruction; highest priority
//   ex_ready        in   EX consumes ex_* this cycle
//   ex_valid        out  ex_* holds a real instruction
//   ex_op_type      out  ALU op code
//   ex_rs/ex_rt     out  source register indices
//   ex_dest         out  write-back index
//   ex_imm          out  sign-extended immediate
//   ex_jtarget      out  jump target field
//   ex_use_imm .. ex_illegal  out  control flags
//   bubble_cnt      out  hazard bubbles inserted (ID_PERF_CNT_EN only)
//   illegal_cnt     out  accepted illegal instructions (ID_PERF_CNT_EN only)
// -----------------------------------------------------------------------------
module id_decode_stage
  import id_decode_stage_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_valid,
  input  logic [DATA_W-1:0]  if_instr,
  output logic               id_ready,
  input  logic               flush,
  input  logic               ex_ready,
  output logic               ex_valid,
  output logic [3:0]         ex_op_type,
  output logic [RADDR_W-1:0] ex_rs,
  output logic [RADDR_W-1:0] ex_rt,
  output logic [RADDR_W-1:0] ex_dest,
  output logic [DATA_W-1:0]  ex_imm,
  output logic [25:0]        ex_jtarget,
  output logic               ex_use_imm,
  output logic               ex_reg_write,
  output logic               ex_mem_read,
  output logic               ex_mem_write,
  output logic               ex_branch,
  output logic               ex_jump,
`ifdef ID_PERF_CNT_EN
  output logic               ex_illegal,
  output logic [CNT_W-1:0]   bubble_cnt,
  output logic [CNT_W-1:0]   illegal_cnt
`else
  output logic               ex_illegal
`endif
);

  // Decoded view of the incoming instruction
  logic [3:0]         dec_op_s;
  logic [RADDR_W-1:0] dec_rs_s;
  logic [RADDR_W-1:0] dec_rt_s;
  logic [RADDR_W-1:0] dec_dest_s;
  logic [DATA_W-1:0]  dec_imm_s;
  logic [25:0]        dec_jt_s;
  ctrl_t              dec_ctrl_s;
  logic               dec_reads_rs_s;
  logic               dec_reads_rt_s;

  // ID/EX register
  logic               ex_valid_r;
  logic [3:0]         ex_op_r;
  logic [RADDR_W-1:0] ex_rs_r;
  logic [RADDR_W-1:0] ex_rt_r;
  logic [RADDR_W-1:0] ex_dest_r;
  logic [DATA_W-1:0]  ex_imm_r;
  logic [25:0]        ex_jt_r;
  ctrl_t              ex_ctrl_r;

  // Handshake / next-state
  logic               hazard_s;
  logic               adv_s;
  logic               load_en_s;
  logic               take_s;
  logic               bubble_s;

  id_decode_stage_comb #(
    .DATA_W  (DATA_W),
    .RADDR_W (RADDR_W)
  ) u_dec (
    .instr    (if_instr),
    .op_type  (dec_op_s),
    .rs       (dec_rs_s),
    .rt       (dec_rt_s),
    .dest     (dec_dest_s),
    .imm      (dec_imm_s),
    .jtarget  (dec_jt_s),
    .ctrl     (dec_ctrl_s),
    .reads_rs (dec_reads_rs_s),
    .reads_rt (dec_reads_rt_s)
  );

  // A load in ID/EX whose result the incoming instruction needs forces one bubble
  assign hazard_s = ex_valid_r & ex_ctrl_r.mem_read & (ex_dest_r != '0) & if_valid &
                    ((dec_reads_rs_s & (dec_rs_s == ex_dest_r)) |
                     (dec_reads_rt_s & (dec_rt_s == ex_dest_r)));

  assign adv_s     = ~ex_valid_r | ex_ready;
  assign id_ready  = flush | (adv_s & ~hazard_s);
  // Register updates on flush or advance; otherwise ID/EX holds (stall)
  assign load_en_s = flush | adv_s;
  // Real instruction enters ID/EX only when nothing squashes or delays it
  assign take_s    = ~flush & adv_s & ~hazard_s & if_valid;
  assign bubble_s  = ~flush & adv_s & hazard_s;

  // ID/EX register: load decoded instruction, or a cleared bubble, or hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_r <= 1'b0;
      ex_op_r    <= 4'd0;
      ex_rs_r    <= '0;
      ex_rt_r    <= '0;
      ex_dest_r  <= '0;
      ex_imm_r   <= '0;
      ex_jt_r    <= 26'd0;
      ex_ctrl_r  <= '0;
    end else if (load_en_s) begin
      ex_valid_r <= take_s;
      ex_op_r    <= take_s ? dec_op_s   : 4'd0;
      ex_rs_r    <= take_s ? dec_rs_s   : '0;
      ex_rt_r    <= take_s ? dec_rt_s   : '0;
      ex_dest_r  <= take_s ? dec_dest_s : '0;
      ex_imm_r   <= take_s ? dec_imm_s  : '0;
      ex_jt_r    <= take_s ? dec_jt_s   : 26'd0;
      ex_ctrl_r  <= take_s ? dec_ctrl_s : '0;
    end
  end

`ifdef ID_PERF_CNT_EN
  logic [CNT_W-1:0] bubble_cnt_r;
  logic [CNT_W-1:0] illegal_cnt_r;

  // Saturating performance counters for hazard bubbles and accepted illegal instrs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt_r  <= '0;
      illegal_cnt_r <= '0;
    end else begin
      if (bubble_s && (bubble_cnt_r != '1)) begin
        bubble_cnt_r <= bubble_cnt_r + CNT_W'(1);
      end
      if (take_s && dec_ctrl_s.illegal && (illegal_cnt_r != '1)) begin
        illegal_cnt_r <= illegal_cnt_r + CNT_W'(1);
      end
    end
  end

  assign bubble_cnt  = bubble_cnt_r;
  assign illegal_cnt = illegal_cnt_r;
`else
  logic unused_s;
  assign unused_s = bubble_s;
`endif

  assign ex_valid     = ex_valid_r;
  assign ex_op_type   = ex_op_r;
  assign ex_rs        = ex_rs_r;
  assign ex_rt        = ex_rt_r;
  assign ex_dest      = ex_dest_r;
  assign ex_imm       = ex_imm_r;
  assign ex_jtarget   = ex_jt_r;
  assign ex_use_imm   = ex_ctrl_r.use_imm;
  assign ex_reg_write = ex_ctrl_r.reg_write;
  assign ex_mem_read  = ex_ctrl_r.mem_read;
  assign ex_mem_write = ex_ctrl_r.mem_write;
  assign ex_branch    = ex_ctrl_r.branch;
  assign ex_jump      = ex_ctrl_r.jump;
  assign ex_illegal   = ex_ctrl_r.illegal;

endmodule

// File: tb/tb_id_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_id_decode_stage
// Directed, table-driven bench for id_decode_stage: each record gives the
// inputs for one cycle, the expected combinational id_ready, and the
// expected ID/EX contents after the following rising edge. Reset state and
// an asynchronous mid-stream reset are checked by hand.
// -----------------------------------------------------------------------------
module tb_id_decode_stage;

  localparam int DATA_W  = 32;
  localparam int RADDR_W = 5;
  localparam int CNT_W   = 16;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               if_valid = 1'b0;
  logic [DATA_W-1:0]  if_instr = 32'h0;
  logic               flush = 1'b0;
  logic               ex_ready = 1'b0;
  logic               id_ready;
  logic               ex_valid;
  logic [3:0]         ex_op_type;
  logic [RADDR_W-1:0] ex_rs;
  logic [RADDR_W-1:0] ex_rt;
  logic [RADDR_W-1:0] ex_dest;
  logic [DATA_W-1:0]  ex_imm;
  logic [25:0]        ex_jtarget;
  logic               ex_use_imm;
  logic               ex_reg_write;
  logic               ex_mem_read;
  logic               ex_mem_write;
  logic               ex_branch;
  logic               ex_jump;
  logic               ex_illegal;
`ifdef ID_PERF_CNT_EN
  logic [CNT_W-1:0]   bubble_cnt;
  logic [CNT_W-1:0]   illegal_cnt;
`endif

  id_decode_stage #(
    .DATA_W  (DATA_W),
    .RADDR_W (RADDR_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .if_valid     (if_valid),
    .if_instr     (if_instr),
    .id_ready     (id_ready),
    .flush        (flush),
    .ex_ready     (ex_ready),
    .ex_valid     (ex_valid),
    .ex_op_type   (ex_op_type),
    .ex_rs        (ex_rs),
    .ex_rt        (ex_rt),
    .ex_dest      (ex_dest),
    .ex_imm       (ex_imm),
    .ex_jtarget   (ex_jtarget),
    .ex_use_imm   (ex_use_imm),
    .ex_reg_write (ex_reg_write),
    .ex_mem_read  (ex_mem_read),
    .ex_mem_write (ex_mem_write),
    .ex_branch    (ex_branch),
    .ex_jump      (ex_jump),
`ifdef ID_PERF_CNT_EN
    .ex_illegal   (ex_illegal),
    .bubble_cnt   (bubble_cnt),
    .illegal_cnt  (illegal_cnt)
`else
    .ex_illegal   (ex_illegal)
`endif
  );

  always #5 clk = ~clk;

  // flags order: {reg_write, use_imm, mem_read, mem_write, branch, jump, illegal}
  typedef struct {
    logic        v;
    logic [31:0] instr;
    logic        er;
    logic        fl;
    logic        rdy;
    logic        ev;
    logic [3:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dest;
    logic [6:0]  flags;
    logic [31:0] imm;
    logic [25:0] jt;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  localparam logic [31:0] I_ADD3  = 32'h00221820; // add $3,$1,$2
  localparam logic [31:0] I_LW5   = 32'h8C250004; // lw  $5,4($1)
  localparam logic [31:0] I_ADD6  = 32'h00A23020; // add $6,$5,$2
  localparam logic [31:0] I_SW5   = 32'hAC250008; // sw  $5,8($1)
  localparam logic [31:0] I_BEQ   = 32'h1022FFFF; // beq $1,$2,-1

  task automatic add_vec(input logic v, input logic [31:0] instr, input logic er, input logic fl,
                         input logic rdy, input logic ev, input logic [3:0] op,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] dest,
                         input logic [6:0] flags, input logic [31:0] imm, input logic [25:0] jt);
    vec_t r;
    r.v = v; r.instr = instr; r.er = er; r.fl = fl; r.rdy = rdy; r.ev = ev; r.op = op;
    r.rs = rs; r.rt = rt; r.dest = dest; r.flags = flags; r.imm = imm; r.jt = jt;
    vecs.push_back(r);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s vec=%0d got=0x%0h want=0x%0h", name, idx, act, exp);
    end
  endtask

  function automatic logic [6:0] act_flags();
    return {ex_reg_write, ex_use_imm, ex_mem_read, ex_mem_write, ex_branch, ex_jump, ex_illegal};
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_ex_valid"}, -1, {31'd0, ex_valid}, 32'd0);
    check({tag, "_op"}, -1, {28'd0, ex_op_type}, 32'd0);
    check({tag, "_regs"}, -1, {17'd0, ex_rs, ex_rt, ex_dest}, 32'd0);
    check({tag, "_flags"}, -1, {25'd0, act_flags()}, 32'd0);
    check({tag, "_imm"}, -1, ex_imm, 32'd0);
    check({tag, "_jt"}, -1, {6'd0, ex_jtarget}, 32'd0);
  endtask

  initial begin
    //      v  instr         er fl rdy ev op     rs  rt  dst flags       imm            jt
    add_vec(1, I_ADD3,       1, 0, 1,  1, 4'd1, 1,  2,  3,  7'b1000000, 32'h00001820, 26'h0221820);
    add_vec(1, 32'h00222022, 1, 0, 1,  1, 4'd2, 1,  2,  4,  7'b1000000, 32'h00002022, 26'h0222022);
    add_vec(1, 32'h00222024, 1, 0, 1,  1, 4'd3, 1,  2,  4,  7'b1000000, 32'h00002024, 26'h0222024);
    add_vec(1, 32'h00222025, 1, 0, 1,  1, 4'd4, 1,  2,  4,  7'b1000000, 32'h00002025, 26'h0222025);
    add_vec(1, 32'h0022202A, 1, 0, 1,  1, 4'd5, 1,  2,  4,  7'b1000000, 32'h0000202A, 26'h022202A);
    add_vec(1, 32'h00220020, 1, 0, 1,  1, 4'd1, 1,  2,  0,  7'b0000000, 32'h00000020, 26'h0220020);
    add_vec(1, I_LW5,        1, 0, 1,  1, 4'd6, 1,  5,  5,  7'b1110000, 32'h00000004, 26'h0250004);
    add_vec(1, I_ADD6,       1, 0, 0,  0, 4'd0, 0,  0,  0,  7'b0000000, 32'h0,        26'h0);
    add_vec(1, I_ADD6,       1, 0, 1,  1, 4'd1, 5,  2,  6,  7'b1000000, 32'h00003020, 26'h0A23020);
    add_vec(1, I_LW5,        1, 0, 1,  1, 4'd6, 1,  5,  5,  7'b1110000, 32'h00000004, 26'h0250004);
    add_vec(1, 32'h08000100, 1, 0, 1,  1, 4'd9, 0,  0,  0,  7'b0000010, 32'h00000100, 26'h0000100);
    add_vec(1, I_LW5,        1, 0, 1,  1, 4'd6, 1,  5,  5,  7'b1110000, 32'h00000004, 26'h0250004);
    add_vec(1, I_SW5,        1, 0, 0,  0, 4'd0, 0,  0,  0,  7'b0000000, 32'h0,        26'h0);
    add_vec(1, I_SW5,        1, 0, 1,  1, 4'd7, 1,  5,  0,  7'b0101000, 32'h00000008, 26'h0250008);
    add_vec(1, I_ADD3,       0, 0, 0,  1, 4'd7, 1,  5,  0,  7'b0101000, 32'h00000008, 26'h0250008);
    add_vec(1, I_ADD3,       0, 0, 0,  1, 4'd7, 1,  5,  0,  7'b0101000, 32'h00000008, 26'h0250008);
    add_vec(1, I_ADD3,       0, 0, 0,  1, 4'd7, 1,  5,  0,  7'b0101000, 32'h00000008, 26'h0250008);
    add_vec(1, I_ADD3,       1, 0, 1,  1, 4'd1, 1,  2,  3,  7'b1000000, 32'h00001820, 26'h0221820);
    add_vec(1, I_BEQ,        1, 1, 1,  0, 4'd0, 0,  0,  0,  7'b0000000, 32'h0,        26'h0);
    add_vec(1, I_BEQ,        1, 0, 1,  1, 4'd8, 1,  2,  0,  7'b0000100, 32'hFFFFFFFF, 26'h022FFFF);
    add_vec(1, 32'hFC000000, 1, 0, 1,  1, 4'd0, 0,  0,  0,  7'b0000001, 32'h0,        26'h0);
    add_vec(1, 32'h8C200000, 1, 0, 1,  1, 4'd6, 1,  0,  0,  7'b0110000, 32'h0,        26'h0200000);
    add_vec(1, 32'h00023020, 1, 0, 1,  1, 4'd1, 0,  2,  6,  7'b1000000, 32'h00003020, 26'h0023020);
    add_vec(0, 32'h0,        1, 0, 1,  0, 4'd0, 0,  0,  0,  7'b0000000, 32'h0,        26'h0);
    add_vec(1, I_LW5,        1, 0, 1,  1, 4'd6, 1,  5,  5,  7'b1110000, 32'h00000004, 26'h0250004);
    add_vec(1, I_ADD6,       0, 0, 0,  1, 4'd6, 1,  5,  5,  7'b1110000, 32'h00000004, 26'h0250004);
    add_vec(1, I_ADD6,       0, 1, 1,  0, 4'd0, 0,  0,  0,  7'b0000000, 32'h0,        26'h0);
    add_vec(1, I_ADD6,       1, 0, 1,  1, 4'd1, 5,  2,  6,  7'b1000000, 32'h00003020, 26'h0A23020);

    // Reset state while rst is held
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
`ifdef ID_PERF_CNT_EN
    check("reset_bubble_cnt", -1, {16'd0, bubble_cnt}, 32'd0);
    check("reset_illegal_cnt", -1, {16'd0, illegal_cnt}, 32'd0);
`endif
    rst = 1'b0;
    #1;
    check("reset_id_ready", -1, {31'd0, id_ready}, 32'd1);

    // Table: drive inputs, check id_ready before the edge, ID/EX after it
    for (int i = 0; i < vecs.size(); i++) begin
      if_valid = vecs[i].v;
      if_instr = vecs[i].instr;
      ex_ready = vecs[i].er;
      flush    = vecs[i].fl;
      #2;
      check("id_ready", i, {31'd0, id_ready}, {31'd0, vecs[i].rdy});
      @(posedge clk);
      #1;
      check("ex_valid", i, {31'd0, ex_valid}, {31'd0, vecs[i].ev});
      check("ex_op_type", i, {28'd0, ex_op_type}, {28'd0, vecs[i].op});
      if (vecs[i].ev) begin
        check("ex_rs", i, {27'd0, ex_rs}, {27'd0, vecs[i].rs});
        check("ex_rt", i, {27'd0, ex_rt}, {27'd0, vecs[i].rt});
        check("ex_dest", i, {27'd0, ex_dest}, {27'd0, vecs[i].dest});
        check("ex_flags", i, {25'd0, act_flags()}, {25'd0, vecs[i].flags});
        check("ex_imm", i, ex_imm, vecs[i].imm);
        check("ex_jtarget", i, {6'd0, ex_jtarget}, {6'd0, vecs[i].jt});
      end
    end

`ifdef ID_PERF_CNT_EN
    // Two hazard bubbles (lw->add, lw->sw) and one accepted illegal opcode
    check("bubble_cnt", -1, {16'd0, bubble_cnt}, 32'd2);
    check("illegal_cnt", -1, {16'd0, illegal_cnt}, 32'd1);
`endif

    // Asynchronous reset in mid-stream: load a lw, then assert rst between edges
    if_valid = 1'b1;
    if_instr = I_LW5;
    ex_ready = 1'b1;
    flush    = 1'b0;
    @(posedge clk);
    #1;
    check("pre_rst_ex_valid", -1, {31'd0, ex_valid}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
`ifdef ID_PERF_CNT_EN
    check("async_rst_bubble_cnt", -1, {16'd0, bubble_cnt}, 32'd0);
    check("async_rst_illegal_cnt", -1, {16'd0, illegal_cnt}, 32'd0);
`endif
    @(posedge clk);
    #1;
    rst      = 1'b0;
    if_instr = I_ADD3;
    @(posedge clk);
    #1;
    check("post_rst_ex_valid", -1, {31'd0, ex_valid}, 32'd1);
    check("post_rst_op", -1, {28'd0, ex_op_type}, 32'd1);
    check("post_rst_dest", -1, {27'd0, ex_dest}, 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
